// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the data-DRAM arbiter.
package dram_arb_pkg;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_EXT  = 2'd2
  } gnt_owner_e;

  localparam int MAX_WAIT_DEF     = 4;
  localparam int LOCK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at LIMIT; clr has priority over inc.
// Registered output, no backpressure.
module sat_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the data DRAM port between the CPU MEM stage and an external master.
// Zero-cycle grant; ext read data returns registered one cycle after its grant.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW           = 14,
  parameter int MAX_WAIT     = MAX_WAIT_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_lock,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [31:0]   ext_rdata,
  output logic          locked,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_spo
);

  localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
  localparam logic [7:0] IDLE_LAST = 8'(LOCK_TIMEOUT - 1);

  arb_state_e state, state_nxt;
  gnt_owner_e owner;
  logic [3:0] wait_cnt;
  logic [7:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // The idle timeout fires on the cycle whose idle increment would reach LOCK_TIMEOUT.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_UNLOCKED: begin
        if (owner == GNT_EXT && ext_lock) state_nxt = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        if (owner == GNT_EXT && !ext_lock) begin
          state_nxt = ARB_UNLOCKED;
        end else if (!ext_req && idle_cnt == IDLE_LAST) begin
          state_nxt = ARB_UNLOCKED;
        end
      end
      default: state_nxt = ARB_UNLOCKED;
    endcase
  end

  always_comb begin
    owner = GNT_NONE;
    case (state)
      ARB_UNLOCKED: begin
        if (ext_req && (!cpu_req || wait_cnt == WAIT_LIM)) begin
          owner = GNT_EXT;
        end else if (cpu_req) begin
          owner = GNT_CPU;
        end
      end
      ARB_LOCKED: begin
        if (ext_req) owner = GNT_EXT;
      end
      default: owner = GNT_NONE;
    endcase
  end

  assign ext_gnt   = (owner == GNT_EXT);
  assign cpu_stall = cpu_req && (owner != GNT_CPU);
  assign locked    = (state == ARB_LOCKED);
  assign cpu_rdata = mem_spo;

  always_comb begin
    mem_a   = cpu_addr;
    mem_we  = 1'b0;
    mem_din = '0;
    case (owner)
      GNT_EXT: begin
        mem_a   = ext_addr;
        mem_we  = ext_we;
        mem_din = ext_wdata;
      end
      GNT_CPU: begin
        mem_we  = cpu_we;
        mem_din = cpu_wdata;
      end
      default: ;
    endcase
  end

  sat_counter #(.W(4), .LIMIT(MAX_WAIT)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ext_req && !ext_gnt),
    .clr (ext_gnt || !ext_req),
    .cnt (wait_cnt)
  );

  sat_counter #(.W(8), .LIMIT(LOCK_TIMEOUT)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((state == ARB_LOCKED) && !ext_req),
    .clr (ext_req || (state_nxt != ARB_LOCKED)),
    .cnt (idle_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_gnt && !ext_we;
      if (ext_gnt && !ext_we) ext_rdata <= mem_spo;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed table, hand sequences and randomized traffic vs a reference model.
module tb_dram_arbiter;

  localparam int AW = 14;
  localparam int MW = 4;
  localparam int LT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [AW-1:0] cpu_addr, ext_addr, mem_a;
  logic [31:0]   cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_din, mem_spo;
  logic          cpu_stall, ext_gnt, ext_rvalid, locked, mem_we;

  always #5 clk = ~clk;

  dram_arbiter #(.AW(AW), .MAX_WAIT(MW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .locked(locked), .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din), .mem_spo(mem_spo)
  );

  // DRAM stand-in: async read, synchronous write, cleared while reset is held.
  logic [31:0] dram [0:255];
  assign mem_spo = dram[mem_a[7:0]];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) dram[i] <= '0;
    else if (mem_we) dram[mem_a[7:0]] <= mem_din;
  end

  // Reference model state
  bit          m_locked, m_rvalid, eg, cg;
  int          m_wait, m_idle, age;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [0:255];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_rvalid = 0; m_rdata = '0;
    m_wait = 0; m_idle = 0; age = 0; eg = 0; cg = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  task automatic drive_cpu(input bit r, input bit w, input logic [AW-1:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_ext(input bit r, input bit w, input bit l, input logic [AW-1:0] a,
                           input logic [31:0] d);
    ext_req = r; ext_we = w; ext_lock = l; ext_addr = a; ext_wdata = d;
  endtask

  // Called at posedge+1; moves to the falling edge and compares against the model.
  task automatic settle();
    #4;
    eg = ext_req && (m_locked || !cpu_req || m_wait >= MW);
    cg = cpu_req && !m_locked && !eg;
    chk("ext_gnt", ext_gnt, eg);
    chk("cpu_stall", cpu_stall, cpu_req && !cg);
    chk("locked", locked, m_locked);
    chk("ext_rvalid", ext_rvalid, m_rvalid);
    chk("ext_rdata", ext_rdata, m_rdata);
    chk("mem_we", mem_we, (eg && ext_we) || (cg && cpu_we));
    chk("mem_a", mem_a, eg ? ext_addr : cpu_addr);
    chk("mem_din", mem_din, eg ? ext_wdata : (cg ? cpu_wdata : 32'h0));
    if (cg && !cpu_we) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:0]]);
    if (eg) chk("ext_wait_bound", (age + 1 <= MW + 1), 1);
  endtask

  task automatic advance();
    @(posedge clk);
    if (eg && ext_we) ref_mem[ext_addr[7:0]] = ext_wdata;
    else if (cg && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
    m_rvalid = eg && !ext_we;
    if (m_rvalid) m_rdata = ref_mem[ext_addr[7:0]];
    if (eg || !ext_req) m_wait = 0;
    else if (m_wait < MW) m_wait++;
    if (ext_req && !eg) age++;
    else age = 0;
    if (!m_locked) begin
      if (eg && ext_lock) m_locked = 1;
    end else begin
      if (ext_req) m_idle = 0;
      else m_idle++;
      if (eg && !ext_lock) m_locked = 0;
      else if (m_idle >= LT) m_locked = 0;
      if (!m_locked) m_idle = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_locked", locked, 0);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_rdata", ext_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit            cr, cw;
    logic [AW-1:0] ca;
    logic [31:0]   cd;
    bit            er;
    logic [AW-1:0] ea;
    bit            x_gnt, x_stall, x_we, x_rvalid;
    int            sel;     // 0: none, 1: check cpu_rdata, 2: check ext_rdata
    logic [31:0]   x_dat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_cpu(0, 0, '0, '0);
    drive_ext(0, 0, 0, '0, '0);

    tbl[0] = '{1, 1, 14'h010, 32'hDEADBEEF, 0, 14'h000, 0, 0, 1, 0, 0, 32'h0};
    tbl[1] = '{1, 0, 14'h010, 32'h0,        0, 14'h000, 0, 0, 0, 0, 1, 32'hDEADBEEF};
    tbl[2] = '{1, 1, 14'h020, 32'hCAFEF00D, 0, 14'h000, 0, 0, 1, 0, 0, 32'h0};
    for (int i = 3; i < 7; i++)
      tbl[i] = '{1, 0, 14'h030, 32'h0, 1, 14'h020, 0, 0, 0, 0, 0, 32'h0};
    tbl[7] = '{1, 0, 14'h030, 32'h0, 1, 14'h020, 1, 1, 0, 0, 0, 32'h0};
    tbl[8] = '{1, 0, 14'h010, 32'h0, 0, 14'h000, 0, 0, 0, 1, 2, 32'hCAFEF00D};
    tbl[9] = '{1, 0, 14'h020, 32'h0, 0, 14'h000, 0, 0, 0, 0, 1, 32'hCAFEF00D};

    apply_reset();

    for (int i = 0; i < 10; i++) begin
      drive_cpu(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd);
      drive_ext(tbl[i].er, 0, 0, tbl[i].ea, '0);
      settle();
      chk($sformatf("tv%0d_gnt", i), ext_gnt, tbl[i].x_gnt);
      chk($sformatf("tv%0d_stall", i), cpu_stall, tbl[i].x_stall);
      chk($sformatf("tv%0d_we", i), mem_we, tbl[i].x_we);
      chk($sformatf("tv%0d_rvalid", i), ext_rvalid, tbl[i].x_rvalid);
      if (tbl[i].sel == 1) chk($sformatf("tv%0d_cpu_rdata", i), cpu_rdata, tbl[i].x_dat);
      if (tbl[i].sel == 2) chk($sformatf("tv%0d_ext_rdata", i), ext_rdata, tbl[i].x_dat);
      advance();
    end

    // Bulk locked write: first grant with CPU idle, then 9 stalled cycles.
    drive_cpu(0, 0, 14'h040, '0);
    drive_ext(1, 1, 1, 14'h000, 32'h100);
    settle(); chk("lk_first_gnt", ext_gnt, 1); advance();
    drive_cpu(1, 0, 14'h040, '0);
    for (int i = 1; i < 10; i++) begin
      drive_ext(1, 1, (i < 9), AW'(i), 32'h100 + i);
      settle();
      chk("lk_stall", cpu_stall, 1);
      chk("lk_locked", locked, 1);
      advance();
    end
    drive_ext(0, 0, 0, '0, '0);
    drive_cpu(1, 0, 14'h005, '0);
    settle();
    chk("lk_released", locked, 0);
    chk("lk_cpu_served", cpu_stall, 0);
    chk("lk_cpu_rdata", cpu_rdata, 32'h105);
    advance();

    // Lock idle timeout.
    drive_cpu(0, 0, '0, '0);
    drive_ext(1, 1, 1, 14'h060, 32'h6666);
    settle(); advance();
    drive_ext(0, 0, 0, '0, '0);
    drive_cpu(1, 0, 14'h060, '0);
    for (int i = 0; i < LT; i++) begin
      settle();
      chk("to_locked", locked, 1);
      chk("to_stall", cpu_stall, 1);
      advance();
    end
    settle();
    chk("to_released", locked, 0);
    chk("to_stall_clear", cpu_stall, 0);
    advance();

    // Reset while locked with an ext read return pending.
    drive_cpu(0, 0, '0, '0);
    drive_ext(1, 1, 1, 14'h050, 32'h5555);
    settle(); advance();
    drive_ext(1, 0, 1, 14'h050, '0);
    settle(); advance();
    chk("pre_rst_rvalid", ext_rvalid, 1);
    chk("pre_rst_locked", locked, 1);
    apply_reset();
    drive_ext(0, 0, 0, '0, '0);
    drive_cpu(1, 0, 14'h050, '0);
    settle();
    chk("post_rst_stall", cpu_stall, 0);
    chk("post_rst_rvalid", ext_rvalid, 0);
    advance();

    // Randomized traffic; ext holds its request until granted.
    eg = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!ext_req || eg) begin
        if ($urandom_range(2) == 0)
          drive_ext(1, $urandom_range(1),
                    m_locked ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0),
                    AW'($urandom_range(63)), $urandom);
        else
          drive_ext(0, 0, 0, '0, '0);
      end
      drive_cpu($urandom_range(9) < 7, $urandom_range(1), AW'($urandom_range(63)), $urandom);
      settle();
      chk("no_double_grant", ext_gnt && !cpu_stall && cpu_req, 0);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
